// File: rtl/apb_resp_pkg.sv
// Shared types and constants for the APB responder slice.
package apb_resp_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned OFS_W    = 4;
   localparam int unsigned CNT_W    = 16;

   localparam int unsigned NUM_GP   = 14;
   localparam int unsigned STAT_OFS = 14;
   localparam int unsigned ID_OFS   = 15;

   localparam logic [ADDR_W-1:0] WIN0_BASE = 32'h8000_0000;
   localparam logic [ADDR_W-1:0] WIN1_BASE = 32'h8400_0000;
   localparam logic [ADDR_W-1:0] WIN2_BASE = 32'h8800_0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

endpackage

// File: rtl/apb_resp_regfile.sv
// General-purpose register storage: one synchronous write port, one combinational read port.
module apb_resp_regfile
   import apb_resp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [OFS_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [OFS_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] regs [NUM_GP];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_GP); i++) regs[i] <= '0;
      end else if (we && (waddr < OFS_W'(NUM_GP))) begin
         regs[waddr] <= wdata;
      end
   end

   // Offsets above the general-purpose range read as zero here; the top muxes them.
   always_comb begin
      rdata_c = '0;
      if (raddr < OFS_W'(NUM_GP)) rdata_c = regs[raddr];
   end

endmodule

// File: rtl/apb_responder.sv
// APB slave with 14 R/W registers, a transfer-count STAT register, an ID register
// and a sticky protocol-error flag.
module apb_responder
   import apb_resp_pkg::*;
#(
   parameter int unsigned       SEL_IDX = 0,
   parameter logic [DATA_W-1:0] ID_VAL  = 32'hA9B0_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        Pselx,
   input  logic              Penable,
   input  logic              Pwrite,
   input  logic [ADDR_W-1:0] Paddr,
   input  logic [DATA_W-1:0] Pwdata,
   output logic [DATA_W-1:0] Prdata,
   output logic              prot_err
);

   state_e            state, state_n;
   logic [OFS_W-1:0]  cap_ofs;
   logic              cap_wr;
   logic [CNT_W-1:0]  wr_cnt, rd_cnt;

   logic              sel_c;
   logic [OFS_W-1:0]  ofs_c;
   logic              setup_c, commit_c, err_c;
   logic              clr_c, wr_inc_c, rd_inc_c;
   logic [DATA_W-1:0] rf_rdata_c, rd_val_c;
   logic              unused_c;

   assign sel_c    = Pselx[SEL_IDX];
   assign ofs_c    = Paddr[5:2];
   assign unused_c = ^{Paddr[ADDR_W-1:6], Paddr[1:0], Pselx};

   // Phase decode: a commit needs a matching setup immediately before it.
   always_comb begin
      state_n  = ST_IDLE;
      setup_c  = 1'b0;
      commit_c = 1'b0;
      err_c    = 1'b0;
      case (state)
         ST_SETUP: begin
            if (sel_c && Penable && (ofs_c == cap_ofs) && (Pwrite == cap_wr)) begin
               commit_c = 1'b1;
               state_n  = ST_ACCESS;
            end else begin
               err_c = 1'b1;
               if (sel_c && !Penable) begin
                  setup_c = 1'b1;
                  state_n = ST_SETUP;
               end
            end
         end
         default: begin
            if (sel_c && !Penable) begin
               setup_c = 1'b1;
               state_n = ST_SETUP;
            end else if (sel_c && Penable) begin
               err_c = 1'b1;
            end
         end
      endcase
   end

   assign clr_c    = commit_c && cap_wr && (cap_ofs == OFS_W'(STAT_OFS));
   assign wr_inc_c = commit_c && cap_wr && (cap_ofs != OFS_W'(STAT_OFS));
   assign rd_inc_c = commit_c && !cap_wr;

   apb_resp_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (commit_c && cap_wr),
      .waddr   (cap_ofs),
      .wdata   (Pwdata),
      .raddr   (ofs_c),
      .rdata_c (rf_rdata_c)
   );

   always_comb begin
      rd_val_c = rf_rdata_c;
      if (ofs_c == OFS_W'(STAT_OFS))    rd_val_c = {wr_cnt, rd_cnt};
      else if (ofs_c == OFS_W'(ID_OFS)) rd_val_c = {ID_VAL[DATA_W-1:2], 2'(SEL_IDX)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cap_ofs <= '0;
         cap_wr  <= 1'b0;
         Prdata  <= '0;
      end else begin
         state <= state_n;
         if (setup_c) begin
            cap_ofs <= ofs_c;
            cap_wr  <= Pwrite;
            if (!Pwrite) Prdata <= rd_val_c;
         end
      end
   end

   // A STAT write clears counters and the error flag, overriding same-edge updates.
   always_ff @(posedge clk) begin
      if (rst || clr_c) begin
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         prot_err <= 1'b0;
      end else begin
         if (wr_inc_c) wr_cnt <= wr_cnt + CNT_W'(1);
         if (rd_inc_c) rd_cnt <= rd_cnt + CNT_W'(1);
         if (err_c)    prot_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_apb_responder.sv
// Directed bench for apb_responder: two instances (SEL_IDX 0 and 2) on one APB bus.
module tb_apb_responder;
   import apb_resp_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  Pselx;
   logic        Penable, Pwrite;
   logic [31:0] Paddr, Pwdata;
   logic [31:0] prdata0, prdata2;
   logic        prot_err0, prot_err2;
   logic [31:0] rd0, rd2;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] W0 = WIN0_BASE;
   localparam logic [31:0] W2 = WIN2_BASE;

   always #5 clk = ~clk;

   apb_responder #(.SEL_IDX(0)) u_dut0 (
      .clk(clk), .rst(rst), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata0), .prot_err(prot_err0)
   );

   apb_responder #(.SEL_IDX(2)) u_dut2 (
      .clk(clk), .rst(rst), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata2), .prot_err(prot_err2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge. Prdata sampled mid access cycle.
   task automatic xfer(input logic [2:0] psel, input logic wr, input logic [31:0] addr_s,
                       input logic [31:0] addr_a, input logic [31:0] wdata);
      Pselx   = psel;
      Penable = 1'b0;
      Pwrite  = wr;
      Paddr   = addr_s;
      Pwdata  = wdata;
      @(negedge clk);
      Penable = 1'b1;
      Paddr   = addr_a;
      rd0     = prdata0;
      rd2     = prdata2;
      @(negedge clk);
   endtask

   task automatic idle();
      Pselx   = 3'b000;
      Penable = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
      rd0 = '0; rd2 = '0;
      repeat (3) @(negedge clk);
      check("rst_prdata0", prdata0, 32'h0);
      check("rst_prot_err0", 32'(prot_err0), 32'h0);
      check("rst_prdata2", prdata2, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back write then read, then STAT
      xfer(3'b001, 1'b1, W0 + 32'h08, W0 + 32'h08, 32'hDEAD_BEEF);
      xfer(3'b001, 1'b0, W0 + 32'h08, W0 + 32'h08, 32'h0);
      check("b2b_read", rd0, 32'hDEAD_BEEF);
      check("unsel_no_resp", rd2, 32'h0);
      xfer(3'b001, 1'b0, W0 + 32'h38, W0 + 32'h38, 32'h0);
      check("stat_1_1", rd0, 32'h0001_0001);

      // Enable without setup
      Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = W0 + 32'h08; Pwdata = 32'h0;
      @(negedge clk);
      check("en_no_setup_err", 32'(prot_err0), 32'h1);
      idle();
      xfer(3'b001, 1'b0, W0 + 32'h08, W0 + 32'h08, 32'h0);
      check("en_no_setup_reg2", rd0, 32'hDEAD_BEEF);
      xfer(3'b001, 1'b1, W0 + 32'h38, W0 + 32'h38, 32'h0);
      idle();
      check("stat_clr_err", 32'(prot_err0), 32'h0);
      check("unsel_no_err", 32'(prot_err2), 32'h0);
      xfer(3'b001, 1'b0, W0 + 32'h38, W0 + 32'h38, 32'h0);
      check("stat_after_clr", rd0, 32'h0);

      // Address changes between setup and access
      xfer(3'b001, 1'b1, W0 + 32'h04, W0 + 32'h04, 32'h1111_1111);
      xfer(3'b001, 1'b1, W0 + 32'h08, W0 + 32'h08, 32'h2222_2222);
      xfer(3'b001, 1'b1, W0 + 32'h04, W0 + 32'h08, 32'h5555_5555);
      idle();
      check("addr_chg_err", 32'(prot_err0), 32'h1);
      xfer(3'b001, 1'b0, W0 + 32'h04, W0 + 32'h04, 32'h0);
      check("addr_chg_reg1", rd0, 32'h1111_1111);
      xfer(3'b001, 1'b0, W0 + 32'h08, W0 + 32'h08, 32'h0);
      check("addr_chg_reg2", rd0, 32'h2222_2222);
      xfer(3'b001, 1'b1, W0 + 32'h38, W0 + 32'h38, 32'h0);

      // Write counter wrap
      force u_dut0.wr_cnt = 16'hFFFF;
      #1;
      release u_dut0.wr_cnt;
      @(negedge clk);
      xfer(3'b001, 1'b0, W0 + 32'h38, W0 + 32'h38, 32'h0);
      check("stat_preset", rd0, 32'hFFFF_0000);
      xfer(3'b001, 1'b1, W0 + 32'h00, W0 + 32'h00, 32'h0BAD_F00D);
      xfer(3'b001, 1'b0, W0 + 32'h38, W0 + 32'h38, 32'h0);
      check("stat_wrap", rd0, 32'h0000_0001);
      xfer(3'b001, 1'b0, W0 + 32'h00, W0 + 32'h00, 32'h0);
      check("reg0_read", rd0, 32'h0BAD_F00D);

      // Reset in the access cycle of a write, then immediate setup
      Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = W0 + 32'h0C; Pwdata = 32'h1234;
      @(negedge clk);
      Penable = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      xfer(3'b001, 1'b0, W0 + 32'h38, W0 + 32'h38, 32'h0);
      check("rst_mid_stat", rd0, 32'h0);
      xfer(3'b001, 1'b0, W0 + 32'h0C, W0 + 32'h0C, 32'h0);
      check("rst_mid_reg3", rd0, 32'h0);

      // SEL_IDX=2 instance: ID read, ignored ID write, STAT, non-onehot select
      xfer(3'b100, 1'b0, W2 + 32'h3C, W2 + 32'h3C, 32'h0);
      check("id_sel2", rd2, 32'hA9B0_0002);
      xfer(3'b100, 1'b1, W2 + 32'h3C, W2 + 32'h3C, 32'hFFFF_FFFF);
      xfer(3'b100, 1'b0, W2 + 32'h3C, W2 + 32'h3C, 32'h0);
      check("id_after_wr", rd2, 32'hA9B0_0002);
      xfer(3'b100, 1'b0, W2 + 32'h38, W2 + 32'h38, 32'h0);
      check("stat_sel2", rd2, 32'h0001_0002);
      xfer(3'b101, 1'b0, W2 + 32'h3C, W2 + 32'h3C, 32'h0);
      check("multi_sel_id0", rd0, 32'hA9B0_0000);
      check("multi_sel_id2", rd2, 32'hA9B0_0002);
      idle();
      check("final_err0", 32'(prot_err0), 32'h0);
      check("final_err2", 32'(prot_err2), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
